// File: rtl/data_bus_if.sv
// data_bus_if: bridges the MEM stage's single-cycle data request onto a
// Wishbone B4 classic bus. Holds the pipeline until the slave acknowledges,
// returns load data, and aborts with a one-cycle error pulse on timeout.
module data_bus_if #(
    parameter int unsigned TIMEOUT = 255   // BUSY cycles without ack before abort (1..255)
) (
    input  logic        clk,
    input  logic        rst,               // asynchronous, active-low
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } state_t;

    // Registered Wishbone master outputs, cleared as one unit.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        cyc;
        logic        stb;
    } wb_req_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    wb_req_t     r_wb;
    logic [31:0] r_rd_buf;
    logic [7:0]  r_tmo_cnt;
    logic        r_bus_err;

    logic        w_timeout;
    logic        w_stallreq;
    logic [31:0] w_cpu_data;
    logic        w_unused;

    // Byte offset is implied by the lane selects; the bus address is word-aligned.
    assign w_unused  = &{1'b0, cpu_addr_i[1:0]};

    // Last permitted BUSY cycle elapsed with no ack; a flush takes priority.
    assign w_timeout = (r_state == ST_BUSY) && !wb_ack_i && !flush_i && (r_tmo_cnt == TMO_LAST);

    // Transaction FSM: issue, wait for ack / flush / timeout, optional hold.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_wb      <= '0;
            r_rd_buf  <= '0;
            r_tmo_cnt <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        r_wb.adr  <= {cpu_addr_i[31:2], 2'b00};
                        r_wb.dat  <= cpu_data_i;
                        r_wb.sel  <= cpu_sel_i;
                        r_wb.we   <= cpu_we_i;
                        r_wb.cyc  <= 1'b1;
                        r_wb.stb  <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush_i) begin
                        r_wb    <= '0;
                        r_state <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        r_wb <= '0;
                        if (!r_wb.we) begin
                            r_rd_buf <= wb_dat_i;
                        end
                        r_state <= stall_i ? ST_HOLD : ST_IDLE;
                    end else if (w_timeout) begin
                        r_wb      <= '0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i || flush_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Same-cycle stall request and load-data return to the MEM stage.
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_stallreq = 1'b0;
        w_cpu_data = '0;
        case (r_state)
            ST_IDLE: w_stallreq = cpu_ce_i && !flush_i;
            ST_BUSY: begin
                if (!flush_i) begin
                    if (wb_ack_i) begin
                        if (!r_wb.we) begin
                            w_cpu_data = wb_dat_i;
                        end
                    end else if (!w_timeout) begin
                        w_stallreq = 1'b1;
                    end
                end
            end
            ST_HOLD: w_cpu_data = r_rd_buf;
            default: ;
        endcase
    end

    assign stallreq_o = w_stallreq;
    assign cpu_data_o = w_cpu_data;
    assign bus_err_o  = r_bus_err;
    assign wb_adr_o   = r_wb.adr;
    assign wb_dat_o   = r_wb.dat;
    assign wb_sel_o   = r_wb.sel;
    assign wb_we_o    = r_wb.we;
    assign wb_cyc_o   = r_wb.cyc;
    assign wb_stb_o   = r_wb.stb;

endmodule

// File: tb/tb_data_bus_if.sv
// tb_data_bus_if: directed, table-driven bench for data_bus_if. Inputs are
// driven on the falling edge and outputs sampled 1 ns later.
module tb_data_bus_if;

    logic        clk;
    logic        rst;
    logic        stall_i, flush_i, cpu_ce_i, cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic        stallreq_o, bus_err_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int n_total = 0;
    int n_bad   = 0;

    data_bus_if #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .bus_err_o  (bus_err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce, we, stall, flush, ack;
        logic [3:0]  sel;
        logic [31:0] addr, wdata, rdata;
        logic        x_sreq;
        logic [31:0] x_data;
        logic        x_cyc, x_we;
        logic [31:0] x_adr;
        logic [3:0]  x_sel;
        logic [31:0] x_dat;
        logic        x_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t v(
        logic ce, logic we, logic [3:0] sel, logic [31:0] addr, logic [31:0] wdata,
        logic stall, logic flush, logic ack, logic [31:0] rdata,
        logic x_sreq, logic [31:0] x_data, logic x_cyc, logic x_we,
        logic [31:0] x_adr, logic [3:0] x_sel, logic [31:0] x_dat, logic x_err);
        vec_t r;
        r.ce = ce; r.we = we; r.sel = sel; r.addr = addr; r.wdata = wdata;
        r.stall = stall; r.flush = flush; r.ack = ack; r.rdata = rdata;
        r.x_sreq = x_sreq; r.x_data = x_data; r.x_cyc = x_cyc; r.x_we = x_we;
        r.x_adr = x_adr; r.x_sel = x_sel; r.x_dat = x_dat; r.x_err = x_err;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic stall, input logic flush, input logic ack,
                         input logic [31:0] rdata);
        cpu_ce_i   = ce;
        cpu_we_i   = we;
        cpu_sel_i  = sel;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        stall_i    = stall;
        flush_i    = flush;
        wb_ack_i   = ack;
        wb_dat_i   = rdata;
    endtask

    task automatic check_all(input string tag, input vec_t e);
        check({tag, ".stallreq"}, 32'(stallreq_o), 32'(e.x_sreq));
        check({tag, ".cpu_data"}, cpu_data_o, e.x_data);
        check({tag, ".cyc"},      32'(wb_cyc_o),   32'(e.x_cyc));
        check({tag, ".stb"},      32'(wb_stb_o),   32'(e.x_cyc));
        check({tag, ".we"},       32'(wb_we_o),    32'(e.x_we));
        check({tag, ".adr"},      wb_adr_o,        e.x_adr);
        check({tag, ".sel"},      32'(wb_sel_o),   32'(e.x_sel));
        check({tag, ".dat"},      wb_dat_o,        e.x_dat);
        check({tag, ".err"},      32'(bus_err_o),  32'(e.x_err));
    endtask

    initial begin
        //            ce we sel   addr       wdata        st fl ak rdata          | sreq data          cyc we adr        sel   dat          err
        // load 0x104, ack two cycles after stb
        vecs[0]  = v(1, 0, 4'hF, 32'h104, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        vecs[1]  = v(1, 0, 4'hF, 32'h104, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          1, 0, 32'h104, 4'hF, 32'h0,        0);
        vecs[2]  = v(1, 0, 4'hF, 32'h104, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          1, 0, 32'h104, 4'hF, 32'h0,        0);
        vecs[3]  = v(1, 0, 4'hF, 32'h104, 32'h0,        0, 0, 1, 32'hDEADBEEF,   0, 32'hDEADBEEF,   1, 0, 32'h104, 4'hF, 32'h0,        0);
        // store to unaligned 0x203, ack in first BUSY cycle
        vecs[4]  = v(1, 1, 4'h8, 32'h203, 32'h5A5A5A5A, 0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        vecs[5]  = v(1, 1, 4'h8, 32'h203, 32'h5A5A5A5A, 0, 0, 1, 32'h11111111,   0, 32'h0,          1, 1, 32'h200, 4'h8, 32'h5A5A5A5A, 0);
        vecs[6]  = v(0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        // flush in second BUSY cycle, beating a simultaneous ack
        vecs[7]  = v(1, 0, 4'hF, 32'h300, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        vecs[8]  = v(1, 0, 4'hF, 32'h300, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          1, 0, 32'h300, 4'hF, 32'h0,        0);
        vecs[9]  = v(1, 0, 4'hF, 32'h300, 32'h0,        0, 1, 1, 32'hCAFEF00D,   0, 32'h0,          1, 0, 32'h300, 4'hF, 32'h0,        0);
        vecs[10] = v(0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        // next request issues normally, then a back-to-back request
        vecs[11] = v(1, 0, 4'h3, 32'h400, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        vecs[12] = v(1, 0, 4'h3, 32'h400, 32'h0,        0, 0, 1, 32'h12345678,   0, 32'h12345678,   1, 0, 32'h400, 4'h3, 32'h0,        0);
        vecs[13] = v(1, 0, 4'hF, 32'h500, 32'h0,        0, 0, 0, 32'h0,          1, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        vecs[14] = v(1, 0, 4'hF, 32'h500, 32'h0,        0, 0, 1, 32'h0BADF00D,   0, 32'h0BADF00D,   1, 0, 32'h500, 4'hF, 32'h0,        0);
        // request killed by flush while IDLE never issues
        vecs[15] = v(1, 0, 4'hF, 32'h600, 32'h0,        0, 1, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);
        vecs[16] = v(0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 32'h0,   4'h0, 32'h0,        0);

        // Reset state
        rst = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        #1;
        check_all("reset", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Table vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ce, vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].wdata,
                  vecs[i].stall, vecs[i].flush, vecs[i].ack, vecs[i].rdata);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // HOLD: ack while pipeline is stalled elsewhere; request stays present
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h600, 32'h0, 1, 0, 0, 32'h0);
        #1; check("hold.issue_sreq", 32'(stallreq_o), 32'd1);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h600, 32'h0, 1, 0, 1, 32'hA5A5F0F0);
        #1; check("hold.ack_data", cpu_data_o, 32'hA5A5F0F0);
        check("hold.ack_sreq", 32'(stallreq_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 0, 4'hF, 32'h600, 32'h0, (k < 2), 0, 0, 32'h0);
            #1;
            check($sformatf("hold%0d.data", k), cpu_data_o, 32'hA5A5F0F0);
            check($sformatf("hold%0d.sreq", k), 32'(stallreq_o), 32'd0);
            check($sformatf("hold%0d.stb", k), 32'(wb_stb_o), 32'd0);
            check($sformatf("hold%0d.cyc", k), 32'(wb_cyc_o), 32'd0);
        end
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        #1; check("hold.exit_data", cpu_data_o, 32'h0);
        check("hold.exit_cyc", 32'(wb_cyc_o), 32'd0);

        // Timeout: TIMEOUT=4, no ack, then a late ack is ignored
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h700, 32'h0, 0, 0, 0, 32'h0);
        #1; check("tmo.issue_sreq", 32'(stallreq_o), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("tmo.busy%0d.sreq", k), 32'(stallreq_o), 32'd1);
            check($sformatf("tmo.busy%0d.cyc", k), 32'(wb_cyc_o), 32'd1);
            check($sformatf("tmo.busy%0d.err", k), 32'(bus_err_o), 32'd0);
        end
        @(negedge clk);
        #1; check("tmo.busy4.sreq", 32'(stallreq_o), 32'd0);
        check("tmo.busy4.data", cpu_data_o, 32'h0);
        check("tmo.busy4.err", 32'(bus_err_o), 32'd0);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 32'hFFFFFFFF);
        #1; check("tmo.err_pulse", 32'(bus_err_o), 32'd1);
        check("tmo.cyc_drop", 32'(wb_cyc_o), 32'd0);
        check("tmo.late_ack_data", cpu_data_o, 32'h0);
        check("tmo.late_ack_sreq", 32'(stallreq_o), 32'd0);
        @(negedge clk);
        #1; check("tmo.err_one_cycle", 32'(bus_err_o), 32'd0);
        check("tmo.still_idle", 32'(wb_cyc_o), 32'd0);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        drive(1, 1, 4'hF, 32'h800, 32'h77777777, 0, 0, 0, 32'h0);
        #1; check("arst.issue_sreq", 32'(stallreq_o), 32'd1);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        #1; check("arst.busy_cyc", 32'(wb_cyc_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_all("arst", v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1; check("arst.after_cyc", 32'(wb_cyc_o), 32'd0);
        check("arst.after_err", 32'(bus_err_o), 32'd0);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h900, 32'h0, 0, 0, 0, 32'h0);
        #1; check("arst.reissue_sreq", 32'(stallreq_o), 32'd1);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h900, 32'h0, 0, 0, 1, 32'h13579BDF);
        #1; check("arst.reissue_adr", wb_adr_o, 32'h900);
        check("arst.reissue_data", cpu_data_o, 32'h13579BDF);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
